mems_spi_arbiter: RTL and testbench
===================================

Name: mems_spi_arbiter

Overview:
- Shares the single DAC SPI master between two command sources:
  - requester 0: the MEMS scan sequencer (SOFTWARE_RESET / VREF / SET_CHANNEL words);
  - requester 1: the host/config path (gain, offset, re-VREF writes).
- Latches one command per requester and grants the master to one of them.
- Runs the start/busy handshake with the master, then returns a done pulse to the owning requester.
- Fixed priority to the scan path, with a starvation limit so config writes cannot be locked out during a long frame.

Parameters:
- DATA_W, 24, width of one SPI command word.
- MAX_CONSEC, 8, maximum consecutive req0 grants while req1 is pending (1..255).
- TIMEOUT, 64, cycles allowed in WAIT_BUSY before abort (only with MEMS_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start0  in  1  req0 command strobe (1 cycle).
- data0  in  DATA_W  req0 command word, valid with start0.
- busy0  out  1  req0 has a command pending or in flight.
- done0  out  1  req0 command completed (1-cycle pulse).
- start1  in  1  req1 command strobe (1 cycle).
- data1  in  DATA_W  req1 command word, valid with start1.
- busy1  out  1  req1 has a command pending or in flight.
- done1  out  1  req1 command completed (1-cycle pulse).
- spi_start  out  1  start strobe to SPI master.
- spi_data  out  DATA_W  word to SPI master, held stable from spi_start until done.
- spi_busy  in  1  SPI master busy.
- drop_err  out  1  sticky: a start arrived while that requester was busy.
- grant_id  out  1  requester currently owning the master.

Behaviour:
- Reset: state IDLE, pend0=pend1=0, consec=0, and all outputs 0 (spi_data=0, grant_id=0, drop_err=0).
- Capture:
  - start_x with pend_x=0 sets pend_x and latches data_x at that edge.
  - start_x with pend_x=1 is ignored and sets drop_err.
  - busy_x = pend_x.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: grant only when (pend0|pend1) and spi_busy=0.
  - Selection: req1 if pend1 and (pend0=0 or consec>=MAX_CONSEC); otherwise req0.
  - On grant, next state is ISSUE, with spi_start=1, spi_data=latched word, grant_id=winner.
- ISSUE: exactly one cycle. spi_start returns to 0; next state WAIT_BUSY.
- WAIT_BUSY: stay until spi_busy=1, then go to WAIT_DONE.
- WAIT_DONE: when spi_busy=0:
  - done_(grant_id)=1 for one cycle;
  - pend_(grant_id) cleared at the same edge;
  - next state IDLE.
- Latency: start0 sampled at edge k, idle and uncontested → spi_start high in the cycle after edge k+1. Minimum turnaround between grants is one IDLE cycle.
- consec:
  - req0 grant while pend1=1 → increment, saturating at 255;
  - any req1 grant, or req0 grant with pend1=0 → reset to 0.
- busy_x falls in the same cycle done_x is high. A start_x in that cycle is accepted with no drop_err.
- If start_x coincides with the grant of x, the command is still pending, so it is dropped with drop_err.
- Reset mid-transfer: everything is cleared. After reset, the arbiter does not grant until the master deasserts spi_busy, which prevents overlapping a stale transfer.
- drop_err clears only on rst.

Optional Feature:
- Macro MEMS_ARB_TIMEOUT_EN. When defined:
  - A counter runs in WAIT_BUSY. After TIMEOUT cycles with spi_busy=0, the arbiter aborts to IDLE.
  - The abort pulses done_x, clears pend_x, and raises added output port timeout_err (sticky, 1-bit, cleared by rst).
- When undefined: no counter, no timeout_err port, and WAIT_BUSY waits indefinitely.

Test Plan:
- Single req0: start0 with data0=24'h280001; master raises busy 2 cycles after spi_start and holds it 30 cycles → spi_start one cycle with spi_data=24'h280001; done0 one cycle after busy falls; busy0 low thereafter.
- Simultaneous: start0 and start1 in the same cycle, consec=0 → req0 granted first, then req1; done0 precedes done1; grant_id sequence 0,1.
- Starvation, MAX_CONSEC=8: req0 re-issues on every done0 while pend1=1 → exactly 8 req0 grants, then a req1 grant, then consec=0 and req0 resumes.
- Drop: start0 twice, 3 cycles apart, before done0 → second ignored; drop_err=1; only the first word is transferred.
- Reset mid-transfer: rst in WAIT_DONE with spi_busy still high 10 more cycles; start1 right after reset → no spi_start until spi_busy=0; then req1 granted normally.
- With MEMS_ARB_TIMEOUT_EN, TIMEOUT=64: master never asserts busy → done0 at 64 cycles after ISSUE; timeout_err=1; state IDLE.

Source files
------------

// File: rtl/mems_spi_arbiter_if.sv
// -----------------------------------------------------------------------------
// mems_spi_arbiter_if
// Bundles the two requester handshakes and the shared SPI-master handshake.
//   master modport : the arbiter side (drives busy/done and spi_start/spi_data)
//   slave  modport : the requesters plus the SPI master (drives start/data and
//                    spi_busy)
// Signals:
//   start0/data0/busy0/done0 : scan sequencer command channel
//   start1/data1/busy1/done1 : host/config command channel
//   spi_start/spi_data       : command strobe and word towards the SPI master
//   spi_busy                 : SPI master busy flag
// -----------------------------------------------------------------------------
interface mems_spi_arbiter_if #(
  parameter int DATA_W = 24
);
  logic              start0;
  logic [DATA_W-1:0] data0;
  logic              busy0;
  logic              done0;
  logic              start1;
  logic [DATA_W-1:0] data1;
  logic              busy1;
  logic              done1;
  logic              spi_start;
  logic [DATA_W-1:0] spi_data;
  logic              spi_busy;

  modport master (
    input  start0, data0, start1, data1, spi_busy,
    output busy0, done0, busy1, done1, spi_start, spi_data
  );

  modport slave (
    output start0, data0, start1, data1, spi_busy,
    input  busy0, done0, busy1, done1, spi_start, spi_data
  );
endinterface

// File: rtl/mems_spi_arbiter.sv
// -----------------------------------------------------------------------------
// mems_spi_arbiter
// Shares one DAC SPI master between the MEMS scan sequencer (requester 0) and
// the host/config path (requester 1). Each requester gets a one-deep command
// latch; the scan path has fixed priority, bounded by a consecutive-grant limit
// so config writes still get through during a long frame.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : mems_spi_arbiter_if.master (requester and SPI handshakes)
//   drop_err     : sticky, a start arrived while that requester was busy
//   grant_id     : requester currently owning the SPI master
//   timeout_err  : sticky, WAIT_BUSY abort happened (MEMS_ARB_TIMEOUT_EN only)
//
// Optional feature macro: MEMS_ARB_TIMEOUT_EN
//   Defined   : WAIT_BUSY aborts to IDLE after TIMEOUT cycles without spi_busy.
//   Undefined : WAIT_BUSY waits indefinitely; no TIMEOUT, no timeout_err.
// -----------------------------------------------------------------------------
module mems_spi_arbiter #(
  parameter int DATA_W     = 24,
  parameter int MAX_CONSEC = 8
`ifdef MEMS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  mems_spi_arbiter_if.master  bus,
  output logic                drop_err,
  output logic                grant_id
`ifdef MEMS_ARB_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic              pend0_r;
  logic              pend1_r;
  logic [DATA_W-1:0] word0_r;
  logic [DATA_W-1:0] word1_r;
  logic [7:0]        consec_r;
  logic              spi_start_r;
  logic [DATA_W-1:0] spi_data_r;
  logic              done0_r;
  logic              done1_r;
  logic              grant_r;
  logic              drop_r;
  logic              sel1_s;

`ifdef MEMS_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0]    tcnt_r;
  logic              tout_r;
  assign timeout_err = tout_r;
`endif

  // Config wins when scan is idle, or once scan has used up its grant budget.
  assign sel1_s = pend1_r & (~pend0_r | (consec_r >= 8'(MAX_CONSEC)));

  assign bus.busy0     = pend0_r;
  assign bus.busy1     = pend1_r;
  assign bus.done0     = done0_r;
  assign bus.done1     = done1_r;
  assign bus.spi_start = spi_start_r;
  assign bus.spi_data  = spi_data_r;
  assign grant_id      = grant_r;
  assign drop_err      = drop_r;

  // Command capture, arbitration FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pend0_r     <= 1'b0;
      pend1_r     <= 1'b0;
      word0_r     <= '0;
      word1_r     <= '0;
      consec_r    <= 8'd0;
      spi_start_r <= 1'b0;
      spi_data_r  <= '0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      grant_r     <= 1'b0;
      drop_r      <= 1'b0;
`ifdef MEMS_ARB_TIMEOUT_EN
      tcnt_r      <= '0;
      tout_r      <= 1'b0;
`endif
    end else begin
      done0_r <= 1'b0;
      done1_r <= 1'b0;

      // A set here and a clear below never hit the same requester in one
      // edge: set needs pend=0, clear needs pend=1.
      if (bus.start0) begin
        if (!pend0_r) begin
          pend0_r <= 1'b1;
          word0_r <= bus.data0;
        end else begin
          drop_r <= 1'b1;
        end
      end
      if (bus.start1) begin
        if (!pend1_r) begin
          pend1_r <= 1'b1;
          word1_r <= bus.data1;
        end else begin
          drop_r <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          // spi_busy gate also keeps us off a master still finishing a
          // transfer that was in flight across a reset.
          if ((pend0_r || pend1_r) && !bus.spi_busy) begin
            state_r     <= ISSUE;
            spi_start_r <= 1'b1;
            grant_r     <= sel1_s;
            spi_data_r  <= sel1_s ? word1_r : word0_r;
            if (!sel1_s && pend1_r) begin
              consec_r <= (consec_r == 8'd255) ? consec_r : consec_r + 8'd1;
            end else begin
              consec_r <= 8'd0;
            end
          end
        end
        ISSUE: begin
          spi_start_r <= 1'b0;
          state_r     <= WAIT_BUSY;
`ifdef MEMS_ARB_TIMEOUT_EN
          tcnt_r      <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (bus.spi_busy) begin
            state_r <= WAIT_DONE;
`ifdef MEMS_ARB_TIMEOUT_EN
          end else if (tcnt_r == TCW'(TIMEOUT - 1)) begin
            // Master never answered: release the requester as if done.
            state_r <= IDLE;
            tout_r  <= 1'b1;
            if (grant_r) begin
              done1_r <= 1'b1;
              pend1_r <= 1'b0;
            end else begin
              done0_r <= 1'b1;
              pend0_r <= 1'b0;
            end
          end else begin
            tcnt_r <= tcnt_r + TCW'(1);
`endif
          end
        end
        WAIT_DONE: begin
          if (!bus.spi_busy) begin
            state_r <= IDLE;
            if (grant_r) begin
              done1_r <= 1'b1;
              pend1_r <= 1'b0;
            end else begin
              done0_r <= 1'b1;
              pend0_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mems_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mems_spi_arbiter
// Scoreboarded bench: expected grants (requester id + word) are queued as the
// stimulus is driven; a monitor pops them on every spi_start and checks the
// matching done pulse. A small SPI-master model answers spi_start with busy.
// -----------------------------------------------------------------------------
module tb_mems_spi_arbiter;
  localparam int DATA_W = 24;

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic drop_err;
  logic grant_id;
`ifdef MEMS_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  mems_spi_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mems_spi_arbiter #(.DATA_W(DATA_W), .MAX_CONSEC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_err (drop_err),
    .grant_id (grant_id)
`ifdef MEMS_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   fall_cyc = 0;
  exp_t grant_q[$];
  exp_t done_q[$];
  logic prev_start = 1'b0;

  // SPI master model controls
  logic m_en, m_never, m_guard;
  int   m_delay, m_hold;
  logic m_busy, force_busy;
  assign bus.spi_busy = m_busy | force_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [DATA_W-1:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    grant_q.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.done0 || bus.done1) && n < limit);
    check_eq("done_within_budget", 32'(bus.done0 | bus.done1), 32'd1);
  endtask

  task automatic mon_start();
    exp_t e;
    check_eq("spi_start_one_cycle", 32'(prev_start), 32'd0);
    check_eq("grant_expected", 32'(grant_q.size() != 0), 32'd1);
    if (grant_q.size() != 0) begin
      e = grant_q.pop_front();
      check_eq("grant_id", 32'(grant_id), 32'(e.id));
      check_eq("spi_data", 32'(bus.spi_data), 32'(e.data));
      done_q.push_back(e);
    end
  endtask

  task automatic mon_done();
    exp_t e;
    check_eq("done_exclusive", 32'(bus.done0 & bus.done1), 32'd0);
    check_eq("done_expected", 32'(done_q.size() != 0), 32'd1);
    if (done_q.size() != 0) begin
      e = done_q.pop_front();
      check_eq("done_id", 32'(bus.done1), 32'(e.id));
      check_eq("done_data_held", 32'(bus.spi_data), 32'(e.data));
      if (!m_never) check_eq("done_after_busy_fall", 32'(cyc), 32'(fall_cyc + 1));
    end
  endtask

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled on the falling edge, away from the DUT edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.spi_start) mon_start();
      if (bus.done0 || bus.done1) mon_done();
    end
    prev_start <= bus.spi_start;
  end

  // SPI master: busy rises m_delay cycles after spi_start, holds m_hold cycles;
  // the optional guard pulse holds off the next grant for one cycle.
  initial begin
    m_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (m_en && bus.spi_start && !m_never) begin
        repeat (m_delay) @(negedge clk);
        m_busy = 1'b1;
        repeat (m_hold) @(negedge clk);
        m_busy = 1'b0;
        fall_cyc = cyc;
        if (m_guard) begin
          @(negedge clk);
          m_busy = 1'b1;
          @(negedge clk);
          m_busy = 1'b0;
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int starts;
    int s_cyc;
    rst = 1'b1;
    bus.start0 = 1'b0; bus.data0 = '0;
    bus.start1 = 1'b0; bus.data1 = '0;
    force_busy = 1'b0;
    m_en = 1'b1; m_never = 1'b0; m_guard = 1'b0;
    m_delay = 2; m_hold = 30;
    repeat (3) @(negedge clk);
    check_eq("rst_busy0", 32'(bus.busy0), 32'd0);
    check_eq("rst_busy1", 32'(bus.busy1), 32'd0);
    check_eq("rst_spi_start", 32'(bus.spi_start), 32'd0);
    check_eq("rst_spi_data", 32'(bus.spi_data), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_drop_err", 32'(drop_err), 32'd0);
    check_eq("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
    rst = 1'b0;

    // Single req0 command
    push_exp(1'b0, 24'h280001);
    bus.start0 = 1'b1; bus.data0 = 24'h280001;
    @(negedge clk);
    bus.start0 = 1'b0; bus.data0 = '0;
    check_eq("single_busy0", 32'(bus.busy0), 32'd1);
    check_eq("single_no_early_start", 32'(bus.spi_start), 32'd0);
    @(negedge clk);
    check_eq("single_latency", 32'(bus.spi_start), 32'd1);
    wait_done(100);
    check_eq("single_done0", 32'(bus.done0), 32'd1);
    check_eq("single_busy0_fall", 32'(bus.busy0), 32'd0);
    @(negedge clk);
    check_eq("single_done_pulse", 32'(bus.done0), 32'd0);

    // Simultaneous requests: scan first, then config
    push_exp(1'b0, 24'h0A0001);
    push_exp(1'b1, 24'h1B0002);
    bus.start0 = 1'b1; bus.data0 = 24'h0A0001;
    bus.start1 = 1'b1; bus.data1 = 24'h1B0002;
    @(negedge clk);
    bus.start0 = 1'b0; bus.start1 = 1'b0;
    wait_done(100);
    check_eq("simul_first_done0", 32'(bus.done0), 32'd1);
    wait_done(100);
    check_eq("simul_second_done1", 32'(bus.done1), 32'd1);

    // Starvation limit: 8 scan grants, one config grant, scan resumes
    m_guard = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(1'b0, 24'h300000 + 24'(i));
    push_exp(1'b1, 24'h3F0000);
    push_exp(1'b0, 24'h300008);
    bus.start0 = 1'b1; bus.data0 = 24'h300000;
    bus.start1 = 1'b1; bus.data1 = 24'h3F0000;
    @(negedge clk);
    bus.start0 = 1'b0; bus.start1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wait_done(200);
      check_eq("starve_done0", 32'(bus.done0), 32'd1);
      bus.start0 = 1'b1; bus.data0 = 24'h300000 + 24'(i);
      @(negedge clk);
      bus.start0 = 1'b0;
    end
    wait_done(200);
    check_eq("starve_req1_granted", 32'(bus.done1), 32'd1);
    wait_done(200);
    check_eq("starve_req0_resumes", 32'(bus.done0), 32'd1);
    check_eq("starve_no_drop", 32'(drop_err), 32'd0);
    m_guard = 1'b0;
    repeat (2) @(negedge clk);

    // Drop: second start0 while the first is still in flight
    push_exp(1'b0, 24'h4D0001);
    bus.start0 = 1'b1; bus.data0 = 24'h4D0001;
    @(negedge clk);
    bus.start0 = 1'b0;
    repeat (2) @(negedge clk);
    bus.start0 = 1'b1; bus.data0 = 24'h4D0002;
    @(negedge clk);
    bus.start0 = 1'b0;
    check_eq("drop_err_set", 32'(drop_err), 32'd1);
    check_eq("drop_busy0", 32'(bus.busy0), 32'd1);
    wait_done(100);
    check_eq("drop_done0", 32'(bus.done0), 32'd1);
    repeat (10) @(negedge clk);
    check_eq("drop_idle_after", 32'(bus.busy0), 32'd0);
    check_eq("drop_err_sticky", 32'(drop_err), 32'd1);

    // Reset in WAIT_DONE while the master stays busy
    m_en = 1'b0;
    push_exp(1'b0, 24'h500001);
    bus.start0 = 1'b1; bus.data0 = 24'h500001;
    @(negedge clk);
    bus.start0 = 1'b0;
    @(negedge clk);
    check_eq("rst_pre_grant", 32'(bus.spi_start), 32'd1);
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_q.delete();
    check_eq("midrst_busy0", 32'(bus.busy0), 32'd0);
    check_eq("midrst_drop_err", 32'(drop_err), 32'd0);
    check_eq("midrst_grant_id", 32'(grant_id), 32'd0);
    push_exp(1'b1, 24'h610002);
    bus.start1 = 1'b1; bus.data1 = 24'h610002;
    @(negedge clk);
    bus.start1 = 1'b0;
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      starts += int'(bus.spi_start);
    end
    check_eq("midrst_hold_off", 32'(starts), 32'd0);
    check_eq("midrst_busy1", 32'(bus.busy1), 32'd1);
    force_busy = 1'b0;
    m_en = 1'b1;
    wait_done(100);
    check_eq("midrst_done1", 32'(bus.done1), 32'd1);

`ifdef MEMS_ARB_TIMEOUT_EN
    // Master never answers: abort after 64 WAIT_BUSY cycles
    repeat (2) @(negedge clk);
    m_never = 1'b1;
    push_exp(1'b0, 24'h700001);
    bus.start0 = 1'b1; bus.data0 = 24'h700001;
    @(negedge clk);
    bus.start0 = 1'b0;
    @(negedge clk);
    s_cyc = cyc;
    check_eq("to_issue", 32'(bus.spi_start), 32'd1);
    wait_done(200);
    check_eq("to_done0", 32'(bus.done0), 32'd1);
    check_eq("to_latency", 32'(cyc - s_cyc), 32'd65);
    check_eq("to_err", 32'(timeout_err), 32'd1);
    m_never = 1'b0;
    @(negedge clk);
    check_eq("to_busy0_clear", 32'(bus.busy0), 32'd0);
`else
    s_cyc = 0;
`endif

    repeat (3) @(negedge clk);
    check_eq("grant_queue_drained", 32'(grant_q.size()), 32'd0);
    check_eq("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
